// File: rtl/pmem_arbiter_if.sv
// Bus bundle for pmem_arbiter: I-cache and D-cache handshakes, the shared pmem port and busy.
interface pmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
);
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_addr;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;
   logic              busy;

   // Arbiter side
   modport slave (
      input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
      output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata, busy
   );

   // Environment side: caches plus pmem
   modport master (
      output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata, busy
   );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one pmem port between I-cache and D-cache, one transaction at a time.
// Optional macro DCACHE_LOCK_EN: a finished D write-back lets a pending D read win the next IDLE cycle.
module pmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input logic           clk,
   input logic           rst_n,
   pmem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_next_s;
   logic              last_d_r;
   logic              op_write_r;
   logic [ADDR_W-1:0] addr_r;
   logic [LINE_W-1:0] wdata_r;
   logic              i_pend_s;
   logic              d_pend_s;
   logic              grant_i_s;
   logic              grant_d_s;
   logic              lock_s;

`ifdef DCACHE_LOCK_EN
   logic lock_r;

   // One-shot lock: armed when a D write-back completes, consumed by the following IDLE cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_r <= 1'b0;
      end else if ((state_r == SERVE_D) && bus.pmem_resp && op_write_r) begin
         lock_r <= 1'b1;
      end else if (state_r == IDLE) begin
         lock_r <= 1'b0;
      end else begin
         lock_r <= lock_r;
      end
   end

   assign lock_s = lock_r;
`else
   assign lock_s = 1'b0;
`endif

   // Grant decision, only meaningful in IDLE
   always_comb begin
      i_pend_s  = bus.i_read;
      d_pend_s  = bus.d_read | bus.d_write;
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
      if (state_r == IDLE) begin
         if (lock_s && bus.d_read) begin
            grant_d_s = 1'b1;
         end else if (i_pend_s && d_pend_s) begin
            grant_d_s = ~last_d_r;
            grant_i_s = last_d_r;
         end else begin
            grant_i_s = i_pend_s;
            grant_d_s = d_pend_s;
         end
      end else begin
         grant_i_s = 1'b0;
         grant_d_s = 1'b0;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_d_s) begin
               state_next_s = SERVE_D;
            end else if (grant_i_s) begin
               state_next_s = SERVE_I;
            end else begin
               state_next_s = IDLE;
            end
         end
         SERVE_I, SERVE_D: begin
            if (bus.pmem_resp) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = state_r;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Transaction latches captured at grant; wdata only moves for a D write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_d_r   <= 1'b0;
         op_write_r <= 1'b0;
         addr_r     <= {ADDR_W{1'b0}};
         wdata_r    <= {LINE_W{1'b0}};
      end else if (grant_d_s) begin
         last_d_r   <= 1'b1;
         op_write_r <= bus.d_write;
         addr_r     <= bus.d_addr;
         if (bus.d_write) begin
            wdata_r <= bus.d_wdata;
         end else begin
            wdata_r <= wdata_r;
         end
      end else if (grant_i_s) begin
         last_d_r   <= 1'b0;
         op_write_r <= 1'b0;
         addr_r     <= bus.i_addr;
         wdata_r    <= wdata_r;
      end else begin
         last_d_r   <= last_d_r;
         op_write_r <= op_write_r;
         addr_r     <= addr_r;
         wdata_r    <= wdata_r;
      end
   end

   // Outputs; resp and rdata follow pmem combinationally so completion is seen the same cycle
   always_comb begin
      bus.busy       = (state_r != IDLE);
      bus.pmem_read  = (state_r != IDLE) && !op_write_r;
      bus.pmem_write = (state_r != IDLE) && op_write_r;
      bus.pmem_addr  = addr_r;
      bus.pmem_wdata = wdata_r;
      bus.i_resp     = (state_r == SERVE_I) && bus.pmem_resp;
      bus.d_resp     = (state_r == SERVE_D) && bus.pmem_resp;
      if (state_r != IDLE) begin
         bus.i_rdata = bus.pmem_rdata;
         bus.d_rdata = bus.pmem_rdata;
      end else begin
         bus.i_rdata = {LINE_W{1'b0}};
         bus.d_rdata = {LINE_W{1'b0}};
      end
   end
endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single physical-memory port between the instruction cache (read-only, line allocate) and the data cache (line allocate and write-back).
- Sits between both cache controllers and pmem.
- Each cache sees an exclusive pmem-style read/write/resp handshake.
- One transaction is in flight at a time. Request, address and write data are latched at grant.

Parameters:
- ADDR_W, 32, pmem byte-address width.
- LINE_W, 256, cache line width in bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous assert, active low.
- i_read  in  1  I-cache line read request; held until i_resp.
- i_addr  in  ADDR_W  I-cache line address.
- i_rdata  out  LINE_W  line data to I-cache.
- i_resp  out  1  I-cache transaction done, one-cycle pulse.
- d_read  in  1  D-cache line read request.
- d_write  in  1  D-cache line write-back request.
- d_addr  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  D-cache write-back data.
- d_rdata  out  LINE_W  line data to D-cache.
- d_resp  out  1  D-cache transaction done, one-cycle pulse.
- pmem_read  out  1  read strobe to pmem.
- pmem_write  out  1  write strobe to pmem.
- pmem_addr  out  ADDR_W  latched address.
- pmem_wdata  out  LINE_W  latched write data.
- pmem_rdata  in  LINE_W  pmem read data.
- pmem_resp  in  1  pmem done.
- busy  out  1  transaction in flight.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, last_grant=I (D wins the first tie).
  - Latched op, addr and wdata cleared.
  - All outputs 0.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - No pmem strobes; busy=0.
  - Request sampling:
    - I request pending: i_read.
    - D request pending: d_read|d_write.
  - Only one requester pending: grant it.
  - Both pending: grant the requester that is not last_grant (round robin).
  - On grant:
    - Latch addr.
    - Latch op: D write if d_write, otherwise read. d_write takes precedence if d_read and d_write are both high.
    - Latch wdata (D write only).
    - Update last_grant.
    - Move to the SERVE_x state.
- SERVE_I / SERVE_D:
  - busy=1.
  - pmem_read or pmem_write driven from the latched op; pmem_addr and pmem_wdata from latches.
  - Strobes stay asserted until pmem_resp.
- On pmem_resp in SERVE_x:
  - x_resp=1 in the same cycle (combinational).
  - x_rdata=pmem_rdata. rdata is don't-care outside resp; drive pmem_rdata to both.
  - Next state is IDLE.
- Latency:
  - Request sampled in IDLE at cycle N, so the strobe is high from cycle N+1.
  - pmem_resp at cycle M gives resp at cycle M and IDLE at M+1.
  - The next grant can occur at M+1, so strobes are high again at M+2.
  - Minimum gap of one strobe-free cycle between transactions.
- Requester drops its request mid-transaction: ignored. The transaction completes and resp is still pulsed.
- Requester changes addr or wdata mid-transaction: ignored (values are latched).
- The non-granted requester waits. Round robin bounds the wait to one transaction.
- pmem_resp in IDLE: ignored; no resp is generated.
- pmem_read and pmem_write are never both high.
- i_resp and d_resp are never both high.

Optional Feature:
- DCACHE_LOCK_EN defined:
  - After a D write completes, the next IDLE cycle grants D if d_read is high, overriding round robin. This makes write-back followed by allocate atomic.
  - last_grant is still updated to D.
  - The lock lasts only that one IDLE cycle; if d_read is low, the lock clears and normal arbitration applies.
- DCACHE_LOCK_EN undefined: pure round robin, no lock state.

Test Plan:
- Reset, then i_read=1 with i_addr=0x100 alone.
  - Required: pmem_read=1 and pmem_addr=0x100 from the next cycle.
  - pmem_resp with pmem_rdata=0xAA..AA gives i_resp=1 and i_rdata=0xAA..AA the same cycle.
  - busy=0 on the following cycle.
- Reset, then i_read and d_read asserted together.
  - Required: D served first, then I after one IDLE cycle.
  - Repeat with both held: grants alternate I, D, I.
- D write: d_write=1, d_addr=0x200, d_wdata=0x55..55.
  - Required: pmem_write=1 with the latched address and data.
  - Change d_addr to 0x300 mid-transaction: pmem_addr stays 0x200.
- D write-back then allocate while i_read is held:
  - Lock disabled: order is D write, I read, D read.
  - DCACHE_LOCK_EN defined: order is D write, D read, I read.
- Assert rst_n=0 while in SERVE_D with pmem_write=1.
  - Required: all outputs 0 immediately (asynchronously).
  - After release: IDLE, and the first tie goes to D.
- d_read and d_write both high: op is write. Inject pmem_resp while IDLE: no resp pulse and no state change.
